// File: rtl/mod_reduce_34_if.sv
// Handshake bundle for mod_reduce_34: product in, modulus side port, residue out.
// Latency: none (wiring only).
// Backpressure: carries AXI-stream style tvalid/tready in both directions.
// Ports: input_* (product stream, towards the reducer), mod_p (modulus side port),
//        output_* (residue stream, away from the reducer, with output_error qualifier).
interface mod_reduce_34_if #(
    parameter int IN_W  = 34,
    parameter int MOD_W = 17
);
    logic [IN_W-1:0]  input_tdata;
    logic             input_tvalid;
    logic             input_tready;
    logic [MOD_W-1:0] mod_p;
    logic [MOD_W-1:0] output_tdata;
    logic             output_tvalid;
    logic             output_tready;
    logic             output_error;

    // Upstream/downstream side (drives products, consumes residues).
    modport master (
        output input_tdata, input_tvalid, mod_p, output_tready,
        input  input_tready, output_tdata, output_tvalid, output_error
    );

    // Reducer side.
    modport slave (
        input  input_tdata, input_tvalid, mod_p, output_tready,
        output input_tready, output_tdata, output_tvalid, output_error
    );
endinterface

// File: rtl/mod_reduce_34.sv
// Sequential restoring shift-subtract reducer: output = input_tdata mod mod_p.
// Latency: residue valid IN_W cycles after the input accept edge; II = IN_W + 2.
// Backpressure: single operation in flight; input_tready low until the residue is taken.
// Ports: clk, rst (sync, active-high); bus (slave modport of mod_reduce_34_if):
//        input_tdata/tvalid/tready, mod_p, output_tdata/tvalid/tready, output_error.
module mod_reduce_34 #(
    parameter int IN_W  = 34,
    parameter int MOD_W = 17
) (
    input  logic            clk,
    input  logic            rst,
    mod_reduce_34_if.slave  bus
);
    localparam int CNT_W = $clog2(IN_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IN_W-1:0]    d_q, d_d;      // dividend, shifted out MSB first
    logic [MOD_W-1:0]   r_q, r_d;      // partial remainder, always < P
    logic [MOD_W-1:0]   p_q, p_d;      // modulus captured at accept
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;

    // Trial value is one bit wider than R. Since R < P <= 2^MOD_W - 1 the
    // real difference T - P fits MOD_W bits, so the low MOD_W bits of a
    // MOD_W-wide subtract are exact and R never needs its extra bit stored.
    logic [MOD_W:0]     t;
    logic               t_ge_p;
    logic [MOD_W-1:0]   t_minus_p;

    always_comb begin
        t         = {r_q, d_q[IN_W-1]};
        t_ge_p    = (t >= {1'b0, p_q});
        t_minus_p = t[MOD_W-1:0] - p_q;
    end

    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        r_d     = r_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (bus.input_tvalid) begin
                    d_d     = bus.input_tdata;
                    p_d     = bus.mod_p;
                    err_d   = (bus.mod_p == '0);
                    r_d     = '0;
                    cnt_d   = CNT_W'(IN_W - 1);
                    state_d = RUN;
                end
            end
            RUN: begin
                // With P == 0 this still iterates; the residue is masked on output.
                r_d = t_ge_p ? t_minus_p : t[MOD_W-1:0];
                d_d = d_q << 1;
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                if (bus.output_tready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            d_q     <= '0;
            r_q     <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            r_q     <= r_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Outputs decode only registered state: no combinational path from
    // output_tready or input_tvalid to any output.
    assign bus.input_tready  = (state_q == IDLE);
    assign bus.output_tvalid = (state_q == DONE);
    assign bus.output_tdata  = ((state_q == DONE) && !err_q) ? r_q : '0;
    assign bus.output_error  = (state_q == DONE) && err_q;
endmodule

// File: doc/mod_reduce_34.md
# mod_reduce_34

Sequential modular reducer placed directly downstream of the 17×17 multiplier in the ElGamal datapath. It accepts a 34-bit product over AXI-stream and computes `product mod p` by restoring shift-subtract, one dividend bit per cycle. `p` is a 17-bit modulus presented on a side port. It returns a 17-bit residue over AXI-stream, so the result can feed the next modular-exponentiation step.

## Interface
- `IN_W`, 34, dividend width; equals iteration count.
- `MOD_W`, 17, modulus and result width.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `input_tdata`  in  IN_W  product to reduce.
- `input_tvalid`  in  1  product valid.
- `input_tready`  out  1  block can accept a product.
- `mod_p`  in  MOD_W  modulus; sampled only on the input-accept edge.
- `output_tdata`  out  MOD_W  residue.
- `output_tvalid`  out  1  residue valid.
- `output_tready`  in  1  downstream accepts residue.
- `output_error`  out  1  qualifies `output_tdata`; high when the sampled modulus was 0.

## Operation
- FSM states: `IDLE`, `RUN`, `DONE`.
- `IDLE`:
  - `input_tready` = 1.
  - On `input_tvalid & input_tready`, latch `input_tdata` into dividend shift register `D`, `mod_p` into `P`, and `(mod_p == 0)` into `err`.
  - Clear remainder `R` (MOD_W+1 bits).
  - Set `cnt` = IN_W-1 and go to `RUN`.
- `RUN`, each cycle:
  - `T` = `{R[MOD_W-1:0], D[IN_W-1]}`.
  - `R` <= (`T >= P`) ? `T - P` : `T`.
  - `D` <= `D << 1`.
  - If `cnt == 0`, go to `DONE`; else `cnt <= cnt - 1`.
- Width rule: `T` is MOD_W+1 bits. Because `R < P ≤ 2^MOD_W - 1`, no bit is lost and `R` always fits MOD_W bits after the subtract.
- `DONE`:
  - `output_tvalid` = 1.
  - `output_tdata` = `R[MOD_W-1:0]`, or 0 if `err`.
  - `output_error` = `err`.
  - On `output_tvalid & output_tready`, go to `IDLE`.
- `err` case (`P == 0`):
  - The iteration still runs 34 cycles, and its result is discarded.
  - `output_tdata` is forced to 0 and `output_error` = 1.
- `P == 1` gives result 0 with `output_error` = 0.
- Outputs are driven from registers or the state decode only; there is no combinational path from `output_tready` or `input_tvalid` to any output.
- `input_tready` is 0 in `RUN` and `DONE`. A new product is never accepted while a result is pending.

## Timing
- Reset values: state `IDLE`; `input_tready` = 1 in the cycle after the reset edge; `output_tvalid` = 0, `output_tdata` = 0, `output_error` = 0; `R`, `D`, `P`, `cnt`, `err` = 0.
- Latency:
  - Input accepted on edge E0.
  - `output_tvalid` rises after edge E34, i.e. IN_W cycles after acceptance.
- Output is held stable, with `output_tdata` and `output_error` unchanged, for as long as `output_tready` = 0.
- Output transfer on edge Ek returns the FSM to `IDLE` at Ek, so `input_tready` = 1 in the following cycle.
- Minimum initiation interval is 36 cycles: accept, 34 RUN cycles, a 1-cycle `DONE` with `output_tready` high, then accept.
- `mod_p` changes outside the accept edge have no effect on an operation in flight.
- Reset asserted mid-`RUN` or mid-`DONE`:
  - State returns to `IDLE` at that edge.
  - `output_tvalid` = 0 in the next cycle, and the pending result is lost.
  - Reset overrides any simultaneous handshake.
- `input_tvalid` may be held high across `RUN` and `DONE`. The same data is accepted once the FSM re-enters `IDLE`.

## Test plan
- `input_tdata` = 0x3_FFFF_FFFF, `mod_p` = 0x10001 -> `output_tdata` = 3, `output_error` = 0, `output_tvalid` rises 34 cycles after accept.
- `input_tdata` = 1000, `mod_p` = 7 -> 6. Then `input_tdata` = 5, `mod_p` = 0x10001 -> 5 (input below modulus). Then `input_tdata` = 0x10001, `mod_p` = 0x10001 -> 0.
- `mod_p` = 0, any input -> `output_tdata` = 0, `output_error` = 1. Next op with `mod_p` = 1 and any input -> 0, `output_error` = 0.
- Backpressure: hold `output_tready` = 0 for 10 cycles after `output_tvalid` rises -> data and valid stable, `input_tready` stays 0. Release -> transfer in 1 cycle, `input_tready` = 1 the next cycle.
- Reset at cycle 15 of `RUN` -> `output_tvalid` never rises for that op, `input_tready` = 1 next cycle. A fresh op of 1000 mod 7 -> 6.
- Randomized back-to-back stream of 200 products of random 17-bit values, random `mod_p` ≥ 2, random `output_tready` -> every result equals the reference `%`, with no drops or duplicates.
